fpnew_mx_block_classifier: RTL and testbench
============================================

FPNEW_MX_BLOCK_CLASSIFIER -- requirements
Module: fpnew_mx_block_classifier

Interface
REQ-001 SHALL have parameter NumLanes, default 8: elements classified per beat.
REQ-002 SHALL have parameter BlockSize, default 32: elements per MX block; must be a multiple of NumLanes (elaboration error otherwise).
REQ-003 SHALL have one clock and one reset: clk_i  in  1  rising-edge clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have fmt_i  in  3  element format (0 E5M2, 1 E4M3, 2 E3M2, 3 E2M3, 4 E2M1, 5-7 illegal).
REQ-005 SHALL have operands_i  in  NumLanes*8  elements, LSB-aligned (FP6 uses [5:0], FP4 uses [3:0]; upper bits ignored).
REQ-006 SHALL have in_valid_i in 1, in_ready_o out 1; beat accepted when both high.
REQ-007 SHALL have info_o  out  NumLanes x fp_info_t  per-lane classification of registered beat.
REQ-008 SHALL have out_valid_o out 1, out_ready_i in 1, out_last_o out 1 (beat is last of block).
REQ-009 SHALL have blk_nan_o out 1, blk_inf_o out 1, blk_zero_cnt_o out clog2(BlockSize+1), blk_max_exp_o out 5: block summary, valid only with out_last_o.

Function
REQ-010 SHALL register one output beat: latency 1 cycle from acceptance to out_valid_o.
REQ-011 SHALL drive in_ready_o = !out_valid_o || out_ready_i; full throughput under continuous ready.
REQ-012 SHALL hold all outputs stable while out_valid_o && !out_ready_i.
REQ-013 SHALL latch fmt_i on first beat of a block; fmt_i ignored on subsequent beats of that block.
REQ-014 SHALL count accepted beats 0..BlockSize/NumLanes-1, wrapping to 0 after last beat; out_last_o set on the beat at final count.
REQ-015 E5M2 classification: exp=all-ones, man=0 -> inf; exp=all-ones, man!=0 -> NaN, signalling when man MSB=0.
REQ-016 E4M3 classification: no inf; only exp=1111,man=111 is NaN (quiet); exp=1111 otherwise normal.
REQ-017 E3M2/E2M3/E2M1: no inf, no NaN; every nonzero exponent normal.
REQ-018 All formats: exp=0,man=0 -> zero; exp=0,man!=0 -> subnormal; is_boxed=1.
REQ-019 Illegal fmt: every lane is_nan=1, is_quiet=1, all other flags 0.
REQ-020 Block summary: blk_nan_o = OR of lane NaN, blk_inf_o = OR of lane inf, blk_zero_cnt_o = count of zero elements, blk_max_exp_o = max raw biased exponent over non-NaN elements (0 if none), all over the full block.
REQ-021 Summary accumulators SHALL update on acceptance and clear after last beat accepted; single-beat blocks (BlockSize=NumLanes) produce summary from that beat alone.

Reset
REQ-022 On rst_i: out_valid_o=0, out_last_o=0, info_o all 0, summary outputs 0, beat counter 0, accumulators 0, latched format 0 (E5M2).
REQ-023 Reset mid-block SHALL discard the partial block; next accepted beat is beat 0.

Configuration
REQ-024 Macro MX_CLASSIFIER_STATS_EN defined: REQ-020/021 accumulators and summary outputs implemented.
REQ-025 Macro undefined: no accumulators; blk_* outputs tied 0; beat counter, out_last_o and per-lane classification unchanged.

Structure
REQ-026 fpnew_pkg SHALL hold mx_fmt_e enum (5 formats), mx_exp_bits()/mx_man_bits() functions, and mx_blk_stats_t struct; fp_info_t reused unchanged.
REQ-027 One combinational sub-module mx_lane_classify (one 8-bit element + format -> fp_info_t and raw exponent), instantiated NumLanes times.

Verification
REQ-028 E5M2, 4 beats, lane0 beat2 = 0x7C, rest 0x3C, ready high -> blk_inf_o=1, blk_nan_o=0, blk_zero_cnt_o=0, blk_max_exp_o=31, out_last_o on 4th output only.
REQ-029 E4M3, element 0x7F and 0x7E -> 0x7F is_nan/is_quiet, 0x7E is_normal; blk_max_exp_o=15 (from 0x7E).
REQ-030 E2M1, all elements 0x0 except one 0x1 -> blk_zero_cnt_o=31, one lane is_subnormal, blk_nan_o=0.
REQ-031 out_ready_i low 3 cycles with out_valid_o high -> in_ready_o low, outputs stable, no beat lost; fmt_i changed mid-block -> no effect until next block.
REQ-032 rst_i pulsed after beat 2 of 4 -> out_valid_o=0 asynchronously; next block's summary contains no data from discarded beats.
REQ-033 fmt_i=6 -> all lanes is_nan=1; with MX_CLASSIFIER_STATS_EN undefined, blk_* stay 0 while out_last_o still toggles every 4th beat.

Source files
------------

// File: rtl/fpnew_mx_block_classifier_pkg.sv
// Shared types and helpers for the MX block classifier.
// Element formats, per-element classification record and block summary record.
package fpnew_mx_block_classifier_pkg;

    // Per-element classification flags, bit-compatible with the FPnew record.
    typedef struct packed {
        logic is_normal;
        logic is_subnormal;
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_signalling;
        logic is_quiet;
        logic is_boxed;
    } fp_info_t;

    // MX element formats; encodings 5..7 are illegal.
    typedef enum logic [2:0] {
        MX_E5M2 = 3'd0,
        MX_E4M3 = 3'd1,
        MX_E3M2 = 3'd2,
        MX_E2M3 = 3'd3,
        MX_E2M1 = 3'd4
    } mx_fmt_e;

    localparam int unsigned MxExpW = 5;
    localparam int unsigned MxCntW = 16;

    // Running summary over the elements of one block.
    typedef struct packed {
        logic              has_nan;
        logic              has_inf;
        logic [MxCntW-1:0] zero_cnt;
        logic [MxExpW-1:0] max_exp;
    } mx_blk_stats_t;

    function automatic logic mx_fmt_legal(input logic [2:0] fmt);
        return fmt <= 3'd4;
    endfunction

    function automatic int unsigned mx_exp_bits(input mx_fmt_e fmt);
        case (fmt)
            MX_E5M2: return 5;
            MX_E4M3: return 4;
            MX_E3M2: return 3;
            MX_E2M3: return 2;
            MX_E2M1: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned mx_man_bits(input mx_fmt_e fmt);
        case (fmt)
            MX_E5M2: return 2;
            MX_E4M3: return 3;
            MX_E3M2: return 2;
            MX_E2M3: return 3;
            MX_E2M1: return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/mx_lane_classify.sv
// Combinational classifier for one MX element.
// Produces the FPnew-style info record and the raw biased exponent.
module mx_lane_classify
    import fpnew_mx_block_classifier_pkg::*;
(
    input  logic [2:0] fmt_i,
    input  logic [7:0] elem_i,
    output fp_info_t   info_o,
    output logic [4:0] exp_o
);

    mx_fmt_e     fmt;
    logic        legal;
    int unsigned eb;
    int unsigned mb;
    logic [7:0]  expMask;
    logic [7:0]  manMask;
    logic [7:0]  man;
    logic [4:0]  expo;
    logic        expOnes;
    logic        manMsb;

    // Split the element into exponent/mantissa fields by format, then classify.
    always_comb begin
        fmt     = mx_fmt_e'(fmt_i);
        legal   = mx_fmt_legal(fmt_i);
        eb      = mx_exp_bits(fmt);
        mb      = mx_man_bits(fmt);
        expMask = 8'((32'd1 << eb) - 32'd1);
        manMask = 8'((32'd1 << mb) - 32'd1);
        man     = elem_i & manMask;
        expo    = 5'((elem_i >> mb) & expMask);
        expOnes = ({3'b000, expo} == expMask);
        manMsb  = |(man & 8'((32'd1 << mb) >> 1));
        info_o  = '0;
        exp_o   = expo;

        if (!legal) begin
            info_o.is_nan   = 1'b1;
            info_o.is_quiet = 1'b1;
            exp_o           = '0;
        end else begin
            info_o.is_boxed = 1'b1;
            if (expo == '0) begin
                if (man == '0) begin
                    info_o.is_zero = 1'b1;
                end else begin
                    info_o.is_subnormal = 1'b1;
                end
            end else if (fmt == MX_E5M2 && expOnes) begin
                if (man == '0) begin
                    info_o.is_inf = 1'b1;
                end else begin
                    info_o.is_nan        = 1'b1;
                    info_o.is_quiet      = manMsb;
                    info_o.is_signalling = !manMsb;
                end
            end else if (fmt == MX_E4M3 && expOnes && man == 8'd7) begin
                info_o.is_nan   = 1'b1;
                info_o.is_quiet = 1'b1;
            end else begin
                info_o.is_normal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpnew_mx_block_classifier.sv
// MX block classifier: classifies NumLanes elements per beat, tracks beat
// position inside a block and (optionally) a NaN/inf/zero/max-exponent summary.
// Optional feature macro: MX_CLASSIFIER_STATS_EN enables the block summary.
module fpnew_mx_block_classifier
    import fpnew_mx_block_classifier_pkg::*;
#(
    parameter int unsigned NumLanes  = 8,
    parameter int unsigned BlockSize = 32
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [2:0]                       fmt_i,
    input  logic [NumLanes*8-1:0]            operands_i,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    output fp_info_t [NumLanes-1:0]          info_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic                             out_last_o,
    output logic                             blk_nan_o,
    output logic                             blk_inf_o,
    output logic [$clog2(BlockSize+1)-1:0]   blk_zero_cnt_o,
    output logic [4:0]                       blk_max_exp_o
);

    localparam int unsigned BeatsPerBlock = BlockSize / NumLanes;
    localparam int unsigned CntW          = (BeatsPerBlock > 1) ? $clog2(BeatsPerBlock) : 1;
    localparam int unsigned ZcW           = $clog2(BlockSize + 1);

    if ((BlockSize % NumLanes) != 0 || BlockSize < NumLanes) begin : gen_cfg_err
        $error("BlockSize must be a nonzero multiple of NumLanes");
    end

    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [2:0]              fmt_q, fmt_d;
    logic                    outValid_q, outValid_d;
    logic                    outLast_q, outLast_d;
    fp_info_t [NumLanes-1:0] info_q, info_d;

    logic                    accept;
    logic                    firstBeat;
    logic                    lastBeat;
    logic [2:0]              fmtEff;
    fp_info_t [NumLanes-1:0] laneInfo;
    logic [NumLanes-1:0][4:0] laneExp;

    assign in_ready_o  = !outValid_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign firstBeat   = (cnt_q == '0);
    assign lastBeat    = (cnt_q == CntW'(BeatsPerBlock - 1));
    // The first beat of a block uses the live format; later beats use the latched one.
    assign fmtEff      = firstBeat ? fmt_i : fmt_q;
    assign out_valid_o = outValid_q;
    assign out_last_o  = outLast_q;
    assign info_o      = info_q;

    for (genvar i = 0; i < NumLanes; i++) begin : gen_lane
        mx_lane_classify u_lane (
            .fmt_i  (fmtEff),
            .elem_i (operands_i[i*8 +: 8]),
            .info_o (laneInfo[i]),
            .exp_o  (laneExp[i])
        );
    end

    // Next-state for the output register, beat counter and latched format.
    always_comb begin
        cnt_d      = cnt_q;
        fmt_d      = fmt_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        info_d     = info_q;
        if (outValid_q && out_ready_i) begin
            outValid_d = 1'b0;
        end
        if (accept) begin
            outValid_d = 1'b1;
            outLast_d  = lastBeat;
            info_d     = laneInfo;
            cnt_d      = lastBeat ? '0 : cnt_q + CntW'(1);
            if (firstBeat) begin
                fmt_d = fmt_i;
            end
        end
    end

    // Output beat, counter and format registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            fmt_q      <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            info_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            fmt_q      <= fmt_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            info_q     <= info_d;
        end
    end

`ifdef MX_CLASSIFIER_STATS_EN
    mx_blk_stats_t beatStats;
    mx_blk_stats_t accBase;
    mx_blk_stats_t merged;
    mx_blk_stats_t acc_q, acc_d;
    logic          blkNan_q, blkNan_d;
    logic          blkInf_q, blkInf_d;
    logic [ZcW-1:0] blkZeroCnt_q, blkZeroCnt_d;
    logic [4:0]    blkMaxExp_q, blkMaxExp_d;

    // Summary contribution of the beat currently on the input.
    always_comb begin
        beatStats = '0;
        for (int i = 0; i < NumLanes; i++) begin
            beatStats.has_nan  = beatStats.has_nan | laneInfo[i].is_nan;
            beatStats.has_inf  = beatStats.has_inf | laneInfo[i].is_inf;
            beatStats.zero_cnt = beatStats.zero_cnt + MxCntW'(laneInfo[i].is_zero);
            if (!laneInfo[i].is_nan && laneExp[i] > beatStats.max_exp) begin
                beatStats.max_exp = laneExp[i];
            end
        end
    end

    // Merge into the running block summary; the first beat starts a fresh summary.
    always_comb begin
        accBase         = firstBeat ? '0 : acc_q;
        merged.has_nan  = accBase.has_nan | beatStats.has_nan;
        merged.has_inf  = accBase.has_inf | beatStats.has_inf;
        merged.zero_cnt = accBase.zero_cnt + beatStats.zero_cnt;
        merged.max_exp  = (beatStats.max_exp > accBase.max_exp) ? beatStats.max_exp : accBase.max_exp;
        acc_d        = acc_q;
        blkNan_d     = blkNan_q;
        blkInf_d     = blkInf_q;
        blkZeroCnt_d = blkZeroCnt_q;
        blkMaxExp_d  = blkMaxExp_q;
        if (accept) begin
            acc_d        = lastBeat ? '0 : merged;
            blkNan_d     = lastBeat & merged.has_nan;
            blkInf_d     = lastBeat & merged.has_inf;
            blkZeroCnt_d = lastBeat ? ZcW'(merged.zero_cnt) : '0;
            blkMaxExp_d  = lastBeat ? merged.max_exp : '0;
        end
    end

    // Accumulator and registered block summary.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q        <= '0;
            blkNan_q     <= 1'b0;
            blkInf_q     <= 1'b0;
            blkZeroCnt_q <= '0;
            blkMaxExp_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            blkNan_q     <= blkNan_d;
            blkInf_q     <= blkInf_d;
            blkZeroCnt_q <= blkZeroCnt_d;
            blkMaxExp_q  <= blkMaxExp_d;
        end
    end

    assign blk_nan_o      = blkNan_q;
    assign blk_inf_o      = blkInf_q;
    assign blk_zero_cnt_o = blkZeroCnt_q;
    assign blk_max_exp_o  = blkMaxExp_q;
`else
    logic unused_lane_exp;

    assign unused_lane_exp = ^laneExp;
    assign blk_nan_o       = 1'b0;
    assign blk_inf_o       = 1'b0;
    assign blk_zero_cnt_o  = '0;
    assign blk_max_exp_o   = '0;
`endif

endmodule

// File: tb/tb_fpnew_mx_block_classifier.sv
// Self-checking bench for fpnew_mx_block_classifier (default 8 lanes, 32-element blocks).
// Summary expectations follow MX_CLASSIFIER_STATS_EN: modelled when defined, zero otherwise.
module tb_fpnew_mx_block_classifier;
    import fpnew_mx_block_classifier_pkg::*;

    localparam int NL    = 8;
    localparam int BS    = 32;
    localparam int BEATS = BS / NL;

`ifdef MX_CLASSIFIER_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    // Info byte encodings {normal,sub,zero,inf,nan,sig,quiet,boxed}
    localparam logic [7:0] NORM = 8'h81;
    localparam logic [7:0] SUB  = 8'h41;
    localparam logic [7:0] ZERO = 8'h21;
    localparam logic [7:0] INF  = 8'h11;
    localparam logic [7:0] QNAN = 8'h0B;
    localparam logic [7:0] SNAN = 8'h0D;
    localparam logic [7:0] ILL  = 8'h0A;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2:0]        fmt_i;
    logic [NL*8-1:0]   operands_i;
    logic              in_valid_i;
    logic              in_ready_o;
    fp_info_t [NL-1:0] info_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              out_last_o;
    logic              blk_nan_o;
    logic              blk_inf_o;
    logic [5:0]        blk_zero_cnt_o;
    logic [4:0]        blk_max_exp_o;

    fpnew_mx_block_classifier #(.NumLanes(NL), .BlockSize(BS)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fmt_i          (fmt_i),
        .operands_i     (operands_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .info_o         (info_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_last_o     (out_last_o),
        .blk_nan_o      (blk_nan_o),
        .blk_inf_o      (blk_inf_o),
        .blk_zero_cnt_o (blk_zero_cnt_o),
        .blk_max_exp_o  (blk_max_exp_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] info;
        logic        last;
        logic        nan;
        logic        inf;
        logic [5:0]  zc;
        logic [4:0]  mexp;
    } expect_t;

    typedef struct {
        logic [2:0] fmt;
        logic [7:0] elem;
        logic [7:0] info;
    } vec_t;

    expect_t sbq[$];
    vec_t    tab[19];
    int      checks   = 0;
    int      failures = 0;

    // Reference model state
    int         mCnt = 0;
    logic [2:0] mFmt = 3'd0;
    logic       aNan, aInf;
    int         aZc, aMax;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [4:0] refExp(input logic [2:0] f, input logic [7:0] e);
        case (f)
            3'd0:    return e[6:2];
            3'd1:    return {1'b0, e[6:3]};
            3'd2:    return {2'b0, e[4:2]};
            3'd3:    return {3'b0, e[4:3]};
            3'd4:    return {3'b0, e[2:1]};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [7:0] refClassify(input logic [2:0] f, input logic [7:0] e);
        logic [4:0] ex;
        logic [2:0] m;
        ex = refExp(f, e);
        case (f)
            3'd0:    m = {1'b0, e[1:0]};
            3'd1:    m = e[2:0];
            3'd2:    m = {1'b0, e[1:0]};
            3'd3:    m = e[2:0];
            3'd4:    m = {2'b0, e[0]};
            default: return ILL;
        endcase
        if (ex == 5'd0) return (m == 3'd0) ? ZERO : SUB;
        if (f == 3'd0 && ex == 5'd31) return (m == 3'd0) ? INF : (m[1] ? QNAN : SNAN);
        if (f == 3'd1 && ex == 5'd15 && m == 3'd7) return QNAN;
        return NORM;
    endfunction

    task automatic modelReset();
        mCnt = 0;
        mFmt = 3'd0;
        aNan = 1'b0; aInf = 1'b0; aZc = 0; aMax = 0;
    endtask

    task automatic modelAccept(input logic [2:0] fmt, input logic [63:0] ops,
                               input bit useTab, input logic [7:0] tabInfo);
        expect_t    e;
        logic [7:0] li, el;
        if (mCnt == 0) begin
            mFmt = fmt;
            aNan = 1'b0; aInf = 1'b0; aZc = 0; aMax = 0;
        end
        for (int i = 0; i < NL; i++) begin
            el = ops[i*8 +: 8];
            li = useTab ? tabInfo : refClassify(mFmt, el);
            e.info[i*8 +: 8] = li;
            if (li[3]) aNan = 1'b1;
            if (li[4]) aInf = 1'b1;
            if (li[5]) aZc++;
            if (!li[3] && int'(refExp(mFmt, el)) > aMax) aMax = int'(refExp(mFmt, el));
        end
        e.last = (mCnt == BEATS - 1);
        e.nan  = StatsEn && e.last && aNan;
        e.inf  = StatsEn && e.last && aInf;
        e.zc   = (StatsEn && e.last) ? 6'(aZc) : 6'd0;
        e.mexp = (StatsEn && e.last) ? 5'(aMax) : 5'd0;
        mCnt   = e.last ? 0 : mCnt + 1;
        sbq.push_back(e);
    endtask

    // Drive one beat, wait (bounded) for acceptance, record its expected output.
    task automatic applyStimulus(input logic [2:0] fmt, input logic [63:0] ops,
                                 input bit useTab, input logic [7:0] tabInfo);
        int waitCyc = 0;
        @(negedge clk_i);
        fmt_i      = fmt;
        operands_i = ops;
        in_valid_i = 1'b1;
        #1;
        while (!in_ready_o && waitCyc < 50) begin
            @(negedge clk_i);
            #1;
            waitCyc++;
        end
        if (!in_ready_o) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=in_ready_o=0 expected=1 within 50 cycles");
        end else begin
            modelAccept(fmt, ops, useTab, tabInfo);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Output monitor: compare each transferred beat against the scoreboard.
    always @(negedge clk_i) begin
        expect_t e;
        #2;
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output actual=out_valid_o=1 expected=no pending beat");
            end else begin
                e = sbq.pop_front();
                checkOutput("info", info_o, e.info);
                checkOutput("last", out_last_o, e.last);
                if (e.last) begin
                    checkOutput("blk_nan", blk_nan_o, e.nan);
                    checkOutput("blk_inf", blk_inf_o, e.inf);
                    checkOutput("blk_zero_cnt", blk_zero_cnt_o, e.zc);
                    checkOutput("blk_max_exp", blk_max_exp_o, e.mexp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] ops;
        logic [63:0] snapInfo;
        logic        snapLast;

        tab[0]  = '{3'd0, 8'h3C, NORM};
        tab[1]  = '{3'd0, 8'h7C, INF};
        tab[2]  = '{3'd0, 8'hFE, QNAN};
        tab[3]  = '{3'd0, 8'h7D, SNAN};
        tab[4]  = '{3'd0, 8'h80, ZERO};
        tab[5]  = '{3'd0, 8'h03, SUB};
        tab[6]  = '{3'd1, 8'h7F, QNAN};
        tab[7]  = '{3'd1, 8'h7E, NORM};
        tab[8]  = '{3'd1, 8'h78, NORM};
        tab[9]  = '{3'd1, 8'h01, SUB};
        tab[10] = '{3'd2, 8'h1F, NORM};
        tab[11] = '{3'd2, 8'hE0, ZERO};
        tab[12] = '{3'd3, 8'h1F, NORM};
        tab[13] = '{3'd3, 8'h07, SUB};
        tab[14] = '{3'd4, 8'h0F, NORM};
        tab[15] = '{3'd4, 8'hF1, SUB};
        tab[16] = '{3'd5, 8'h00, ILL};
        tab[17] = '{3'd6, 8'h3C, ILL};
        tab[18] = '{3'd7, 8'h7C, ILL};

        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        fmt_i = 3'd0; operands_i = '0;
        modelReset();
        #12;
        checkOutput("rst_out_valid", out_valid_o, 0);
        checkOutput("rst_out_last", out_last_o, 0);
        checkOutput("rst_info", info_o, 0);
        checkOutput("rst_blk_nan", blk_nan_o, 0);
        checkOutput("rst_blk_inf", blk_inf_o, 0);
        checkOutput("rst_blk_zero_cnt", blk_zero_cnt_o, 0);
        checkOutput("rst_blk_max_exp", blk_max_exp_o, 0);
        checkOutput("rst_in_ready", in_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table: every vector is sent as a full block so its format is latched.
        for (int v = 0; v < 19; v++) begin
            for (int b = 0; b < BEATS; b++) begin
                applyStimulus(tab[v].fmt, {NL{tab[v].elem}}, 1'b1, tab[v].info);
            end
        end

        // E5M2: one infinity in lane 0 of beat 2
        for (int b = 0; b < BEATS; b++) begin
            ops = {NL{8'h3C}};
            if (b == 2) ops[7:0] = 8'h7C;
            applyStimulus(3'd0, ops, 1'b0, 8'h00);
        end

        // E4M3: NaN 0x7F excluded from max exponent, 0x7E contributes 15
        for (int b = 0; b < BEATS; b++) begin
            ops = '0;
            if (b == 0) begin
                ops[7:0]  = 8'h7F;
                ops[15:8] = 8'h7E;
            end
            applyStimulus(3'd1, ops, 1'b0, 8'h00);
        end

        // E2M1: all zero except one subnormal
        for (int b = 0; b < BEATS; b++) begin
            ops = '0;
            if (b == 3) ops[47:40] = 8'h01;
            applyStimulus(3'd4, ops, 1'b0, 8'h00);
        end

        // Backpressure with a mid-block format change
        applyStimulus(3'd2, {NL{8'h7C}}, 1'b0, 8'h00);
        @(negedge clk_i);
        out_ready_i = 1'b0;
        fmt_i       = 3'd0;
        operands_i  = {NL{8'h7C}};
        in_valid_i  = 1'b1;
        #1;
        snapInfo = info_o;
        snapLast = out_last_o;
        checkOutput("stall_in_ready", in_ready_o, 0);
        checkOutput("stall_out_valid", out_valid_o, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            #1;
            checkOutput("stall_in_ready", in_ready_o, 0);
            checkOutput("stall_out_valid", out_valid_o, 1);
            checkOutput("stall_info_stable", info_o, snapInfo);
            checkOutput("stall_last_stable", out_last_o, snapLast);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int b = 1; b < BEATS; b++) begin
            applyStimulus(3'd0, {NL{8'h7C}}, 1'b0, 8'h00);
        end
        for (int b = 0; b < BEATS; b++) begin
            applyStimulus(3'd0, {NL{8'h7C}}, 1'b0, 8'h00);
        end

        // Reset after two beats of a block discards the partial block
        applyStimulus(3'd0, {NL{8'h7C}}, 1'b0, 8'h00);
        applyStimulus(3'd0, {NL{8'h7C}}, 1'b0, 8'h00);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_out_valid", out_valid_o, 0);
        checkOutput("async_rst_out_last", out_last_o, 0);
        checkOutput("async_rst_info", info_o, 0);
        sbq.delete();
        modelReset();
        #1;
        rst_i = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            applyStimulus(3'd0, {NL{8'h3C}}, 1'b0, 8'h00);
        end

        for (int c = 0; c < 20 && sbq.size() != 0; c++) begin
            @(negedge clk_i);
        end
        @(negedge clk_i);
        #3;
        checkOutput("drain_pending", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
